// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, entry struct and state encoding for the ALU result stage
package alu_pkg;

    // Default geometry; the entry struct is sized from these.
    localparam int ALU_N       = 4;
    localparam int ALU_NUM_OPS = 11;
    localparam int ALU_OP_W    = 4;

    // Operation codes
    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] OP_NOTA = 4'd4;
    localparam logic [ALU_OP_W-1:0] OP_NOTB = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_ASHL = 4'd7;
    localparam logic [ALU_OP_W-1:0] OP_ASHR = 4'd8;
    localparam logic [ALU_OP_W-1:0] OP_LSHL = 4'd9;
    localparam logic [ALU_OP_W-1:0] OP_LSHR = 4'd10;

    // Bit positions inside the 4-bit flag field {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [ALU_N-1:0]    res;
        logic [3:0]          flags;
        logic                err;
        logic [ALU_OP_W-1:0] op;
    } alu_entry_t;

    // Occupancy of the main/skid pair
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/alu_flag_sel.sv
// rtl/alu_flag_sel.sv - combinational result select with N/Z/C/V and illegal-op generation
module alu_flag_sel
    import alu_pkg::*;
#(
    parameter int N       = ALU_N,
    parameter int NUM_OPS = ALU_NUM_OPS,
    parameter int OP_W    = ALU_OP_W
) (
    input  logic [OP_W-1:0]      operation,
    input  logic [NUM_OPS*N-1:0] results,
    input  logic [NUM_OPS-1:0]   carry_vec,
    input  logic [NUM_OPS-1:0]   ovf_vec,
    output alu_entry_t           entry
);

    logic [N-1:0] sel;
    logic         carry;
    logic         ovf;
    logic         legal;

    // Decode the op code against every legal slot; an unmatched code marks the entry illegal
    always_comb begin
        sel   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        legal = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (operation == OP_W'(k)) begin
                sel   = results[k*N +: N];
                carry = carry_vec[k];
                ovf   = ovf_vec[k];
                legal = 1'b1;
            end
        end
    end

    // Build the entry; illegal codes deliver zero with only the Zero flag set
    always_comb begin
        entry    = '0;
        entry.op = operation;
        if (legal) begin
            entry.res           = sel;
            entry.flags[FLAG_N] = sel[N-1];
            entry.flags[FLAG_Z] = (sel == '0);
            entry.flags[FLAG_C] = carry;
            entry.flags[FLAG_V] = ovf;
            entry.err           = 1'b0;
        end else begin
            entry.res           = '0;
            entry.flags[FLAG_Z] = 1'b1;
            entry.err           = 1'b1;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage with valid/ready and 2-entry skid buffer
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N       = ALU_N,
    parameter int NUM_OPS = ALU_NUM_OPS,
    parameter int OP_W    = ALU_OP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      operation,
    input  logic [NUM_OPS*N-1:0] results,
    input  logic [NUM_OPS-1:0]   carry_vec,
    input  logic [NUM_OPS-1:0]   ovf_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out,
    output logic [3:0]           flags,
    output logic                 op_err,
    output logic [OP_W-1:0]      out_op
);

    stage_state_t state, state_next;
    alu_entry_t   cap;
    alu_entry_t   main_q;
    alu_entry_t   skid_q;
    logic         accept;
    logic         drain;
    logic         load_main;
    logic         load_skid;
    logic         move_skid;

    alu_flag_sel #(
        .N       (N),
        .NUM_OPS (NUM_OPS),
        .OP_W    (OP_W)
    ) u_flag_sel (
        .operation (operation),
        .results   (results),
        .carry_vec (carry_vec),
        .ovf_vec   (ovf_vec),
        .entry     (cap)
    );

    // Handshake qualifiers and occupancy transitions; in_ready depends on state and rst only
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state)
            ST_EMPTY: begin
                in_ready  = !rst;
                out_valid = 1'b0;
            end
            ST_ONE: begin
                in_ready  = !rst;
                out_valid = 1'b1;
            end
            ST_TWO: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
        accept = in_valid && in_ready;
        drain  = out_valid && out_ready;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_ONE;
                    load_main  = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_main  = 1'b1;
                end else if (accept) begin
                    state_next = ST_TWO;
                    load_skid  = 1'b1;
                end else if (drain) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_next = ST_ONE;
                    move_skid  = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // State and entry registers; reset discards both entries regardless of handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_next;
            if (load_main) begin
                main_q <= cap;
            end else if (move_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= cap;
            end
        end
    end

    assign out    = main_q.res;
    assign flags  = main_q.flags;
    assign op_err = main_q.err;
    assign out_op = main_q.op;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered, parametrised successor to the combinational ALU result selector. It selects one of NUM_OPS per-operation results by operation code and computes N/Z/C/V flags at the same time. It registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the ALU can drive downstream logic such as the display/register-file path without combinational paths or data loss under backpressure. It sits between the per-operation datapath units and the ALU consumer.

Parameters:
N, 4, data width of every operation result and of the output
NUM_OPS, 11, number of selectable operations (codes 0..NUM_OPS-1)
OP_W, 4, width of the operation code; must satisfy 2**OP_W >= NUM_OPS

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents operation/results this cycle
in_ready  output  1  stage can accept this cycle
operation  input  OP_W  operation code (0=add, 1=sub, 2=and, 3=or, 4=notA, 5=notB, 6=xor, 7=ashl, 8=ashr, 9=lshl, 10=lshr)
results  input  NUM_OPS*N  packed per-op results, op k at bits [k*N +: N]
carry_vec  input  NUM_OPS  carry-out per op; bit k used when op k is selected
ovf_vec  input  NUM_OPS  signed overflow per op
out_valid  output  1  out/flags/op_err/out_op hold a valid entry
out_ready  input  1  downstream accepts this cycle
out  output  N  selected result
flags  output  4  {Neg, Zero, Carry, oVerflow}
op_err  output  1  entry was captured with operation >= NUM_OPS
out_op  output  OP_W  operation code of the entry on out

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: out_valid=0, out=0, flags=0, op_err=0, out_op=0, both buffer entries invalid, state EMPTY. in_ready=0 while rst is high.
- Accept: in_valid && in_ready at an edge. Drain: out_valid && out_ready at an edge.
- Capture, computed combinationally from inputs:
  - sel = results[operation*N +: N]
  - Neg = sel[N-1]; Zero = (sel==0); Carry = carry_vec[operation]; oVerflow = ovf_vec[operation]
- Illegal code (operation >= NUM_OPS): out=0, flags={0,1,0,0}, op_err=1. The entry is still accepted and delivered.
- Latency: an entry accepted at edge t appears on out at t+1 when the stage was EMPTY or draining.
- States by occupancy:
  - EMPTY: in_ready=1, out_valid=0. Accept -> ONE (main register loaded).
  - ONE: in_ready=1, out_valid=1.
    - accept && drain -> ONE, main register reloaded with the new entry.
    - accept && !drain -> TWO, new entry goes to the skid register.
    - drain && !accept -> EMPTY.
    - neither -> ONE, hold.
  - TWO: in_ready=0, out_valid=1. Drain -> ONE, skid moves to main. No drain -> hold.
- in_ready is driven from state only, with no combinational path from out_ready.
- Stability: while out_valid && !out_ready, out/flags/op_err/out_op must not change.
- Ordering: entries leave strictly in acceptance order. Nothing is dropped or duplicated.
- in_valid while in_ready=0: ignored. Upstream must hold its inputs.
- rst asserted mid-operation: all entries are discarded at that edge, regardless of in_valid/out_ready.

Decomposition:
- Package alu_pkg holds:
  - localparam op codes (OP_ADD=0 .. OP_LSHR=10)
  - typedef struct packed {logic [N-1:0] res; logic [3:0] flags; logic err; logic [OP_W-1:0] op;} alu_entry_t (parametrised through package constants, N=4/OP_W=4 defaults)
  - flag bit index constants
- Sub-module alu_flag_sel: combinational select plus flag/err generation, producing alu_entry_t. The top holds the state machine and the main/skid registers.

Test Plan:
- Reset and idle: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out=0, flags=0. After release, in_ready=1 next cycle.
- Basic select/flags (N=4): op=1, results[1]=4'b0000, carry_vec[1]=1 -> one cycle later out=0, flags=4'b0110. Then op=0, results[0]=4'b1001, ovf_vec[0]=1 -> out=9, flags=4'b1001, out_op=0.
- Backpressure/skid: out_ready=0, send ops 2 then 6 on back-to-back cycles -> after the second accept in_ready=0. out holds the op-2 entry stable for 5 cycles. Raise out_ready -> op 2 then op 6 delivered in order, in_ready returns to 1.
- Full throughput: out_ready=1, in_valid=1 for 20 cycles with op cycling 0..10 -> 20 outputs on 20 consecutive cycles, in order, in_ready never low.
- Illegal op: op=13 with arbitrary results -> out=0, flags=4'b0100, op_err=1, out_op=13, delivered like a normal entry.
- Reset mid-stream: stage in TWO with out_ready=0, assert rst one cycle -> out_valid=0 next cycle. Neither stored entry ever appears on out.
